// File: rtl/g11620_emu.sv
// g11620_emu: sensor-side responder for the G11620 InGaAs line sensor RESET/AD_SP
// handshake. Times the integration pulse, answers its falling edge with AD_SP,
// then streams one line of pixel data and an end-of-scan pulse.
// Optional feature: define G11620_EMU_ABORT_CNT_EN to build the abort counter;
// without it abort_cnt_o is tied to zero.
module g11620_emu #(
    parameter int PIX_NUM     = 512,
    parameter int NOP_DLY     = 4,
    parameter int INTEG_SHIFT = 0,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sens_reset_in,
    output logic              ad_sp_o,
    output logic [DATA_W-1:0] video_o,
    output logic              video_vld_o,
    output logic              eos_o,
    output logic              busy_o,
    output logic [15:0]       frame_cnt_o,
    output logic [15:0]       abort_cnt_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INTEG = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_SP    = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_EOS   = 3'd5;

    // A zero or negative delay still needs one DELAY sample before AD_SP.
    localparam int          NOP_EFF  = (NOP_DLY < 1) ? 1 : NOP_DLY;
    localparam logic [31:0] NOP_CNT  = 32'(NOP_EFF);
    localparam logic [15:0] LAST_PIX = 16'(PIX_NUM - 1);
    localparam logic [32:0] VMAX     = (33'd1 << DATA_W) - 33'd1;

    logic [2:0]        state_q, state_d;
    logic [31:0]       integ_cnt_q, integ_cnt_d;
    logic [31:0]       dly_cnt_q, dly_cnt_d;
    logic [15:0]       pix_idx_q, pix_idx_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              ad_sp_q, ad_sp_d;
    logic              video_vld_q, video_vld_d;
    logic [DATA_W-1:0] video_q, video_d;
    logic              eos_q, eos_d;
    logic              busy_q, busy_d;
    logic              abort_hit;

    // Pixel value: shifted integration count plus index, saturating at full scale.
    function automatic logic [DATA_W-1:0] pixel(input logic [31:0] integ,
                                                input logic [15:0] idx);
        logic [32:0] v;
        v = {1'b0, (integ >> INTEG_SHIFT)} + {17'd0, idx};
        if (v > VMAX) begin
            return '1;
        end
        return v[DATA_W-1:0];
    endfunction

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d     = state_q;
        integ_cnt_d = integ_cnt_q;
        dly_cnt_d   = dly_cnt_q;
        pix_idx_d   = pix_idx_q;
        frame_cnt_d = frame_cnt_q;
        abort_hit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sens_reset_in) begin
                    state_d     = S_INTEG;
                    integ_cnt_d = 32'd1;
                end
            end
            S_INTEG: begin
                if (sens_reset_in) begin
                    if (integ_cnt_q != 32'hFFFF_FFFF) begin
                        integ_cnt_d = integ_cnt_q + 32'd1;
                    end
                end else begin
                    state_d   = S_DELAY;
                    dly_cnt_d = 32'd1;
                end
            end
            S_DELAY: begin
                if (sens_reset_in) begin
                    abort_hit = 1'b1;
                end else if (dly_cnt_q >= NOP_CNT) begin
                    state_d = S_SP;
                end else begin
                    dly_cnt_d = dly_cnt_q + 32'd1;
                end
            end
            S_SP: begin
                if (sens_reset_in) begin
                    abort_hit = 1'b1;
                end else begin
                    state_d   = S_DATA;
                    pix_idx_d = 16'd0;
                end
            end
            S_DATA: begin
                if (sens_reset_in) begin
                    abort_hit = 1'b1;
                end else if (pix_idx_q == LAST_PIX) begin
                    state_d     = S_EOS;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    pix_idx_d = pix_idx_q + 16'd1;
                end
            end
            S_EOS: begin
                // A high sample here is deliberately ignored; IDLE picks it up.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // The sample that aborts a readout is the first integration sample.
        if (abort_hit) begin
            state_d     = S_INTEG;
            integ_cnt_d = 32'd1;
        end
        ad_sp_d     = (state_d == S_SP);
        video_vld_d = (state_d == S_DATA);
        video_d     = video_vld_d ? pixel(integ_cnt_q, pix_idx_d) : '0;
        eos_d       = (state_d == S_EOS);
        busy_d      = (state_d != S_IDLE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            integ_cnt_q <= '0;
            dly_cnt_q   <= '0;
            pix_idx_q   <= '0;
            frame_cnt_q <= '0;
            ad_sp_q     <= 1'b0;
            video_vld_q <= 1'b0;
            video_q     <= '0;
            eos_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            integ_cnt_q <= integ_cnt_d;
            dly_cnt_q   <= dly_cnt_d;
            pix_idx_q   <= pix_idx_d;
            frame_cnt_q <= frame_cnt_d;
            ad_sp_q     <= ad_sp_d;
            video_vld_q <= video_vld_d;
            video_q     <= video_d;
            eos_q       <= eos_d;
            busy_q      <= busy_d;
        end
    end

`ifdef G11620_EMU_ABORT_CNT_EN
    logic [15:0] abort_cnt_q, abort_cnt_d;

    // Count aborted readouts; wraps naturally and clears only on reset.
    always_comb begin
        abort_cnt_d = abort_cnt_q;
        if (abort_hit) begin
            abort_cnt_d = abort_cnt_q + 16'd1;
        end
    end

    // Abort counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            abort_cnt_q <= '0;
        end else begin
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign abort_cnt_o = abort_cnt_q;
`else
    assign abort_cnt_o = 16'd0;
`endif

    assign ad_sp_o     = ad_sp_q;
    assign video_o     = video_q;
    assign video_vld_o = video_vld_q;
    assign eos_o       = eos_q;
    assign busy_o      = busy_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_g11620_emu.sv
// Testbench for g11620_emu: random and directed RESET waveforms, with expected
// outputs derived per edge from line/abort intervals computed over the waveform.
module tb_g11620_emu;

    localparam int PIX      = 64;
    localparam int NOP      = 4;
    localparam int SH       = 1;
    localparam int DW       = 12;
    localparam int LINE_LOW = NOP + PIX + 2;

    logic          clk;
    logic          rst_n;
    logic          sens_reset_in;
    logic          ad_sp_o;
    logic [DW-1:0] video_o;
    logic          video_vld_o;
    logic          eos_o;
    logic          busy_o;
    logic [15:0]   frame_cnt_o;
    logic [15:0]   abort_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit stim[$];

    g11620_emu #(
        .PIX_NUM(PIX), .NOP_DLY(NOP), .INTEG_SHIFT(SH), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sens_reset_in(sens_reset_in),
        .ad_sp_o(ad_sp_o), .video_o(video_o), .video_vld_o(video_vld_o),
        .eos_o(eos_o), .busy_o(busy_o), .frame_cnt_o(frame_cnt_o),
        .abort_cnt_o(abort_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input bit v, input int n);
        for (int i = 0; i < n; i++) stim.push_back(v);
    endtask

    function automatic int pix_val(input int n, input int k);
        longint v;
        v = longint'(n >>> SH) + longint'(k);
        if (v > (64'd1 << DW) - 1) return (1 << DW) - 1;
        return int'(v);
    endfunction

    // Plays stim from IDLE; expected outputs come from line/abort intervals.
    task automatic run_seq(input int frm0, input int abt0, output int frm_end, output int abt_end);
        int T, t, start, e0, n, last, a, stop, k, frames, aborts, ea;
        bit resume;
        bit e_sp[], e_vld[], e_eos[], e_busy[], frm_inc[], abt_inc[];
        int e_vid[];
        T = stim.size();
        e_sp = new[T]; e_vld = new[T]; e_eos = new[T]; e_busy = new[T];
        frm_inc = new[T]; abt_inc = new[T]; e_vid = new[T];
        t = 0;
        resume = 0;
        while (t < T) begin
            if (!resume) begin
                while (t < T && !stim[t]) t++;
                if (t >= T) break;
            end
            resume = 0;
            start = t;
            e0 = start;
            while (e0 < T && stim[e0]) begin
                e_busy[e0] = 1;
                e0++;
            end
            if (e0 >= T) break;
            n = e0 - start;
            last = e0 + NOP + 1 + PIX;
            a = -1;
            for (int i = e0 + 1; i <= last && i < T; i++) begin
                if (stim[i]) begin
                    a = i;
                    break;
                end
            end
            stop = (a >= 0) ? a : last + 1;
            for (int i = e0; i < stop && i < T; i++) begin
                e_busy[i] = 1;
                if (i == e0 + NOP) e_sp[i] = 1;
                k = i - (e0 + NOP + 1);
                if (k >= 0 && k < PIX) begin
                    e_vld[i] = 1;
                    e_vid[i] = pix_val(n, k);
                end
                if (i == last) begin
                    e_eos[i] = 1;
                    frm_inc[i] = 1;
                end
            end
            if (a >= 0) begin
                abt_inc[a] = 1;
                t = a;
                resume = 1;
            end else begin
                t = last + 2;
            end
        end
        frames = frm0;
        aborts = abt0;
        for (int i = 0; i < T; i++) begin
            @(negedge clk);
            sens_reset_in = stim[i];
            @(posedge clk);
            #1;
            frames = (frames + int'(frm_inc[i])) & 16'hFFFF;
            aborts = (aborts + int'(abt_inc[i])) & 16'hFFFF;
`ifdef G11620_EMU_ABORT_CNT_EN
            ea = aborts;
`else
            ea = 0;
`endif
            check($sformatf("ad_sp@%0d", i), 64'(ad_sp_o), 64'(e_sp[i]));
            check($sformatf("vld@%0d", i), 64'(video_vld_o), 64'(e_vld[i]));
            check($sformatf("video@%0d", i), 64'(video_o), 64'(e_vid[i]));
            check($sformatf("eos@%0d", i), 64'(eos_o), 64'(e_eos[i]));
            check($sformatf("busy@%0d", i), 64'(busy_o), 64'(e_busy[i]));
            check($sformatf("frame@%0d", i), 64'(frame_cnt_o), 64'(frames));
            check($sformatf("abort@%0d", i), 64'(abort_cnt_o), 64'(ea));
        end
        $display("[TB] sequence of %0d cycles done: frames=%0d aborts=%0d", T, frames, aborts);
        @(negedge clk);
        sens_reset_in = 1'b0;
        stim.delete();
        frm_end = frames;
        abt_end = aborts;
    endtask

    task automatic check_all_zero(input string where);
        check({where, ":ad_sp"}, 64'(ad_sp_o), 64'd0);
        check({where, ":vld"}, 64'(video_vld_o), 64'd0);
        check({where, ":video"}, 64'(video_o), 64'd0);
        check({where, ":eos"}, 64'(eos_o), 64'd0);
        check({where, ":busy"}, 64'(busy_o), 64'd0);
        check({where, ":frame"}, 64'(frame_cnt_o), 64'd0);
        check({where, ":abort"}, 64'(abort_cnt_o), 64'd0);
    endtask

    initial begin
        int f, ab, mode;
        rst_n = 1'b0;
        sens_reset_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: plain line, saturation, aborts in DATA/DELAY/SP, back-to-back.
        push(0, 3); push(1, 10); push(0, LINE_LOW + 1);
        push(1, 8150); push(0, LINE_LOW + 1);
        push(1, 5); push(0, NOP + 1 + 20); push(1, 5); push(0, LINE_LOW + 1);
        push(1, 4); push(0, 2); push(1, 3); push(0, LINE_LOW + 1);
        push(1, 7); push(0, LINE_LOW); push(1, 6); push(0, LINE_LOW + 1);
        push(1, 3); push(0, NOP + 1); push(1, 2); push(0, LINE_LOW + 1);
        // Random mix of full lines, random-length lows and back-to-back pulses.
        for (int r = 0; r < 12; r++) begin
            push(0, $urandom_range(0, 3));
            push(1, $urandom_range(1, 40));
            mode = $urandom_range(0, 2);
            if (mode == 0) push(0, LINE_LOW + 1);
            else if (mode == 1) push(0, $urandom_range(1, NOP + PIX + 1));
            else push(0, LINE_LOW);
        end
        push(0, LINE_LOW + 2);
        run_seq(0, 0, f, ab);

        // Line cut by rst_n in the middle of DATA.
        push(0, 2); push(1, 6); push(0, NOP + 1 + 30);
        run_seq(f, ab, f, ab);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midline_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // A full line must follow the reset with counters restarting at zero.
        push(0, 1); push(1, 9); push(0, LINE_LOW + 2);
        run_seq(0, 0, f, ab);
        check("post_rst_frames", 64'(frame_cnt_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
